// File: rtl/result_display.sv
// result_display: samples the dice/traffic mux output, keeps recent dice throws and
// scans a 4-digit seven-segment display. Define RESULT_HISTORY_EN for four entries (else h0 only).
module result_display #(
    parameter int SCAN_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sel,
    input  logic       button,
    input  logic [2:0] result,
    output logic [6:0] seg,
    output logic [3:0] an
);

`ifdef RESULT_HISTORY_EN
    localparam int HIST_DEPTH = 4;
`else
    localparam int HIST_DEPTH = 1;
`endif
    localparam int               CNT_W       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(SCAN_DIV - 1);
    localparam logic [6:0]       GLYPH_BLANK = 7'b0000000;
    localparam logic [6:0]       GLYPH_DASH  = 7'b1000000;
    localparam logic [6:0]       SEG_A       = 7'b0000001;
    localparam logic [6:0]       SEG_D       = 7'b0001000;
    localparam logic [6:0]       SEG_G       = 7'b1000000;

    function automatic logic [6:0] dice_glyph(input logic [2:0] v);
        logic [6:0] g;
        case (v)
            3'd1:    g = 7'b0000110;
            3'd2:    g = 7'b1011011;
            3'd3:    g = 7'b1001111;
            3'd4:    g = 7'b1100110;
            3'd5:    g = 7'b1101101;
            3'd6:    g = 7'b1111101;
            default: g = GLYPH_DASH;
        endcase
        return g;
    endfunction

    logic [CNT_W-1:0]      r_div_cnt;
    logic [1:0]            r_dig;
    logic                  r_btn_q;
    logic [2:0]            r_h_val [HIST_DEPTH];
    logic [HIST_DEPTH-1:0] r_h_vld;
    logic [6:0]            r_seg;
    logic [3:0]            r_an;

    logic                  w_capture;
    logic [6:0]            w_hist_glyph [4];
    logic [6:0]            w_seg_next;

    assign w_capture = r_btn_q & ~button & ~sel;

    // Digit scan: dwell SCAN_DIV cycles per digit, then advance to the next.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div_cnt <= {CNT_W{1'b0}};
            r_dig     <= 2'd0;
        end else if (r_div_cnt == CNT_LAST) begin
            r_div_cnt <= {CNT_W{1'b0}};
            r_dig     <= r_dig + 2'd1;
        end else begin
            r_div_cnt <= r_div_cnt + CNT_W'(1);
        end
    end

    // Previous button level; starts low so a button held through reset needs a fresh release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_btn_q <= 1'b0;
        end else begin
            r_btn_q <= button;
        end
    end

    // Throw history: newest entry in slot 0, older entries shift outward.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < HIST_DEPTH; i++) begin
                r_h_val[i] <= 3'd0;
            end
            r_h_vld <= {HIST_DEPTH{1'b0}};
        end else if (w_capture) begin
            r_h_val[0] <= result;
            r_h_vld[0] <= 1'b1;
            for (int i = 1; i < HIST_DEPTH; i++) begin
                r_h_val[i] <= r_h_val[i-1];
                r_h_vld[i] <= r_h_vld[i-1];
            end
        end else begin
            r_h_vld <= r_h_vld;
        end
    end

    // Glyph for each history slot; slots that do not exist stay blank.
    always_comb begin
        for (int d = 0; d < 4; d++) begin
            w_hist_glyph[d] = GLYPH_BLANK;
        end
        for (int d = 0; d < HIST_DEPTH; d++) begin
            w_hist_glyph[d] = r_h_vld[d] ? dice_glyph(r_h_val[d]) : GLYPH_BLANK;
        end
    end

    // Segment pattern for the digit currently being scanned.
    always_comb begin
        w_seg_next = GLYPH_BLANK;
        if (sel) begin
            case (r_dig)
                2'd0:    w_seg_next = result[0] ? SEG_D : GLYPH_BLANK;
                2'd1:    w_seg_next = result[1] ? SEG_G : GLYPH_BLANK;
                2'd2:    w_seg_next = result[2] ? SEG_A : GLYPH_BLANK;
                default: w_seg_next = GLYPH_BLANK;
            endcase
        end else if ((r_dig == 2'd0) && button) begin
            w_seg_next = dice_glyph(result);
        end else begin
            w_seg_next = w_hist_glyph[r_dig];
        end
    end

    // Registered display drive.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_seg <= GLYPH_BLANK;
            r_an  <= 4'b0000;
        end else begin
            r_seg <= w_seg_next;
            r_an  <= 4'b0001 << r_dig;
        end
    end

    assign seg = r_seg;
    assign an  = r_an;

endmodule

// File: tb/tb_result_display.sv
// Directed bench for result_display: a frame-level model checks every cycle, literal glyph checks pin it.
module tb_result_display;

    localparam int SCAN_DIV = 4;
`ifdef RESULT_HISTORY_EN
    localparam int HIST_DEPTH = 4;
`else
    localparam int HIST_DEPTH = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sel = 1'b0;
    logic       button = 1'b0;
    logic [2:0] result = 3'd0;
    logic [6:0] seg;
    logic [3:0] an;

    int total = 0;
    int bad   = 0;

    result_display #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk(clk), .rst(rst), .sel(sel), .button(button),
        .result(result), .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    // ---------------- model ----------------
    logic [6:0] glyph_tab [8] = '{7'b1000000, 7'b0000110, 7'b1011011, 7'b1001111,
                                  7'b1100110, 7'b1101101, 7'b1111101, 7'b1000000};
    logic [2:0] m_hist [$];
    int         m_edges = 0;
    logic       m_prev  = 1'b0;
    logic [6:0] exp_seg = 7'd0;
    logic [3:0] exp_an  = 4'd0;

    function automatic logic [6:0] model_digit(input int d);
        if (sel) begin
            if (d == 2) return result[2] ? 7'b0000001 : 7'b0000000;
            if (d == 1) return result[1] ? 7'b1000000 : 7'b0000000;
            if (d == 0) return result[0] ? 7'b0001000 : 7'b0000000;
            return 7'b0000000;
        end
        if (d == 0 && button) return glyph_tab[result];
        if (d < m_hist.size()) return glyph_tab[m_hist[d]];
        return 7'b0000000;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_edges = 0;
                m_prev  = 1'b0;
                m_hist.delete();
                exp_seg = 7'd0;
                exp_an  = 4'd0;
            end else begin
                int d;
                d = (m_edges / SCAN_DIV) % 4;
                exp_an  = 4'(1 << d);
                exp_seg = model_digit(d);
                if (m_prev && !button && !sel) begin
                    m_hist.push_front(result);
                    if (m_hist.size() > HIST_DEPTH) void'(m_hist.pop_back());
                end
                m_prev  = button;
                m_edges = m_edges + 1;
            end
        end
    end

    task automatic check(input string name, input logic [6:0] got, input logic [6:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %b want %b at %0t", name, got, want, $time);
        end
    endtask

    // Per-cycle comparison against the model, just after each active edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            check("cyc_seg", seg, exp_seg);
            check("cyc_an", {3'b000, an}, {3'b000, exp_an});
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wait_an(input string name, input logic [3:0] target, output bit found);
        found = 1'b0;
        for (int i = 0; i < 4*SCAN_DIV+4; i++) begin
            if (an === target) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!found) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: an=%b never reached %b", name, an, target);
        end
    endtask

    task automatic check_digit(input string name, input int d, input logic [6:0] lit);
        bit found;
        repeat (2) @(negedge clk);
        wait_an(name, 4'(1 << d), found);
        if (found) begin
            check(name, seg, lit);
            check({name, "_model"}, exp_seg, lit);
        end
    endtask

    task automatic roll(input logic [2:0] v);
        button = 1'b1;
        result = v;
        @(negedge clk);
        button = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit found;
        repeat (3) @(negedge clk);
        check("rst_seg", seg, 7'b0000000);
        check("rst_an", {3'b000, an}, 7'b0000000);
        rst = 1'b1;
        @(negedge clk);
        check("an_first", {3'b000, an}, 7'b0000001);
        repeat (SCAN_DIV) @(negedge clk);
        check("an_second", {3'b000, an}, 7'b0000010);
        wait_an("an_wrap", 4'b1000, found);
        repeat (SCAN_DIV) @(negedge clk);
        check("an_wrap", {3'b000, an}, 7'b0000001);

        button = 1'b1;
        result = 3'd3;
        check_digit("live3", 0, 7'b1001111);
        button = 1'b0;
        result = 3'd5;
        check_digit("cap5", 0, 7'b1101101);
        check_digit("cap5_d1", 1, 7'b0000000);
        check_digit("cap5_d3", 3, 7'b0000000);

        roll(3'd2); roll(3'd4); roll(3'd6); roll(3'd1); roll(3'd3);
        check_digit("four_d0", 0, 7'b1001111);
`ifdef RESULT_HISTORY_EN
        check_digit("four_d1", 1, 7'b0000110);
        check_digit("four_d2", 2, 7'b1111101);
        check_digit("four_d3", 3, 7'b1100110);
`else
        check_digit("four_d1", 1, 7'b0000000);
        check_digit("four_d3", 3, 7'b0000000);
`endif

        roll(3'd7);
        check_digit("inv_d0", 0, 7'b1000000);
        sel    = 1'b1;
        result = 3'd2;
        button = 1'b1;
        @(negedge clk);
        button = 1'b0;
        @(negedge clk);
        sel    = 1'b0;
        result = 3'd0;
        check_digit("selign_d0", 0, 7'b1000000);
`ifdef RESULT_HISTORY_EN
        check_digit("selign_d1", 1, 7'b1001111);
`endif

        sel    = 1'b1;
        result = 3'b110;
        check_digit("trf_d2", 2, 7'b0000001);
        check_digit("trf_d1", 1, 7'b1000000);
        check_digit("trf_d0", 0, 7'b0000000);
        check_digit("trf_d3", 3, 7'b0000000);
        result = 3'b001;
        check_digit("trf_green", 0, 7'b0001000);
        sel    = 1'b0;
        result = 3'd0;
        check_digit("back_d0", 0, 7'b1000000);
`ifdef RESULT_HISTORY_EN
        check_digit("back_d1", 1, 7'b1001111);
        check_digit("back_d2", 2, 7'b0000110);
        check_digit("back_d3", 3, 7'b1111101);
`endif

        wait_an("mid_rst", 4'b0100, found);
        rst = 1'b0;
        #1;
        check("midrst_seg", seg, 7'b0000000);
        check("midrst_an", {3'b000, an}, 7'b0000000);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        check_digit("post_d0", 0, 7'b0000000);
        check_digit("post_d1", 1, 7'b0000000);
        check_digit("post_d2", 2, 7'b0000000);
        check_digit("post_d3", 3, 7'b0000000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
